// File: rtl/dot_acc_pkg.sv
// Shared types and parameter defaults for the dot-product accumulator.
package dot_acc_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam int PROD_W_DEF = 8;
   localparam int LEN_DEF    = 4;
   localparam int ACC_W_DEF  = 12;

endpackage

// File: rtl/dot_acc_adder.sv
// One accumulate step at ACC_W+1 bits; the carry out is the overflow event.
// DOT_PRODUCT_ACC_SAT_EN: clamp to all-ones on overflow instead of wrapping.
module dot_acc_adder
   import dot_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] prod,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   logic [ACC_W:0] wide;

   assign wide = {1'b0, acc} + (ACC_W+1)'(prod);
   assign ovf  = wide[ACC_W];

`ifdef DOT_PRODUCT_ACC_SAT_EN
   // A clamped acc re-overflows on any nonzero add, so it stays pinned.
   assign sum = ovf ? '1 : wide[ACC_W-1:0];
`else
   assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/dot_product_accumulator.sv
// Accumulates groups of LEN products and presents each sum on a handshake.
// Build option DOT_PRODUCT_ACC_SAT_EN selects saturating accumulation.
module dot_product_accumulator
   import dot_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int LEN    = LEN_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf
);

   localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nxt;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic             add_ovf;
   logic             in_fire;
   logic             out_fire;
   logic             last;

   dot_acc_adder #(
      .PROD_W(PROD_W),
      .ACC_W (ACC_W)
   ) u_adder (
      .acc (acc),
      .prod(in_prod),
      .sum (acc_nxt),
      .ovf (add_ovf)
   );

   // Refuse input during the reset cycle; otherwise state-decoded only.
   assign in_ready  = (state == ACCUM) && !rst;
   assign out_valid = (state == HOLD);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign last      = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ACCUM: if (in_fire && last) state_nxt = HOLD;
         HOLD:  if (out_fire) state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         out_sum <= '0;
         out_ovf <= 1'b0;
      end else if (in_fire) begin
         if (last) begin
            out_sum <= acc_nxt;
            out_ovf <= ovf | add_ovf;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
         end else begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            ovf <= ovf | add_ovf;
         end
      end
   end

endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Sequential stage directly downstream of the 4-bit combinational multiplier. It consumes a stream of 8-bit unsigned products over a valid/ready handshake and accumulates every group of LEN products into one dot-product sum. It then presents that sum on a second valid/ready handshake. Together with the multiplier, it forms a small MAC datapath.

## Interface
- PROD_W, 8: product width; matches the multiplier's `out`.
- LEN, 4: number of products per dot product; must be ≥ 2.
- ACC_W, 12: accumulator and result width; must be ≥ PROD_W.
- clk  input  1  sole clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_prod is valid.
- in_ready  output  1  block accepts a product this cycle.
- in_prod  input  PROD_W  unsigned product from the multiplier.
- out_valid  output  1  out_sum and out_ovf are valid.
- out_ready  input  1  downstream takes the result.
- out_sum  output  ACC_W  completed dot-product sum.
- out_ovf  output  1  an overflow occurred while accumulating this result.

## Operation
- Two-state FSM:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Transfer rules: an input transfer happens when in_valid && in_ready; an output transfer happens when out_valid && out_ready.
- In ACCUM, on each input transfer:
  - acc ← acc + zero-extended in_prod. The addition is computed at ACC_W+1 bits; the carry out is the overflow event.
  - cnt increments. cnt is $clog2(LEN) bits wide and counts 0..LEN-1.
  - An overflow event sets the sticky ovf bit.
- Completion: an input transfer with cnt==LEN-1 loads out_sum with the final acc+in_prod, loads out_ovf, and moves the FSM to HOLD. acc, cnt and ovf then clear to 0.
- In HOLD, out_sum and out_ovf stay stable until an output transfer; the output transfer returns the FSM to ACCUM.
- in_valid is ignored in HOLD. The block never buffers a product while a result is pending.
- in_valid low in ACCUM stalls accumulation; partial state is held indefinitely.
- Reset values: FSM=ACCUM, in_ready=0 during the reset cycle and 1 afterwards, out_valid=0, out_sum=0, out_ovf=0, acc=0, cnt=0.
- Reset mid-group or in HOLD discards the partial sum and any pending result.

## Timing
- Fixed latency: out_valid rises in the cycle after the LEN-th input transfer.
- Best-case throughput is one result per LEN+1 cycles: LEN input cycles plus one HOLD cycle when out_ready=1.
- in_ready deasserts in the cycle after the LEN-th transfer and reasserts in the cycle after the output transfer.
- out_ready high in HOLD: the output transfer completes in that cycle, and the next product can transfer in the following cycle.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. in_ready and out_valid are decoded from the registered FSM state only.

## Configuration
- DOT_PRODUCT_ACC_SAT_EN defined: on an overflow event acc clamps to all-ones and stays there for the rest of the group; out_sum = 2^ACC_W-1.
- DOT_PRODUCT_ACC_SAT_EN undefined: acc wraps modulo 2^ACC_W.
- out_ovf reports overflow identically in both builds.

## Structure
- Shared package dot_acc_pkg holds:
  - the state typedef (enum ACCUM, HOLD);
  - PROD_W_DEF = 8 and LEN_DEF = 4, which the parameter defaults reference.
- One sub-module is natural: dot_acc_adder. It is a combinational ACC_W+1-bit adder that outputs the next acc and the overflow event; saturation is selected inside it under the macro.
- The FSM, counter and output registers live in the top module.

## Test plan
- Back-to-back group: in_prod = 6, 32, 60, 143 with in_valid held high and out_ready=1 → out_valid for exactly one cycle, one cycle after the 4th transfer, with out_sum=241, out_ovf=0; in_ready is low that cycle.
- Back-pressure: same group with out_ready=0 for 5 cycles → out_sum holds 241 for those 5 cycles; in_ready stays 0; products offered meanwhile are not counted. The next group 1, 1, 1, 1 → out_sum=4.
- Input gaps: 10, (in_valid=0 for 3 cycles), 20, 30, 40 → out_sum=100; latency is measured from the last transfer.
- Overflow with ACC_W=8: four products of 225 → out_ovf=1. With the macro, out_sum=255; without it, out_sum=132 (900 mod 256). The next group 1, 2, 3, 4 → out_sum=10, out_ovf=0.
- Reset mid-group: 50, 50, then rst for 1 cycle, then 1, 2, 3, 4 → out_sum=10. During the rst cycle, out_valid=0 and in_ready=0.
- Reset in HOLD: assert rst while out_valid=1 → the next cycle has out_valid=0, out_sum=0, FSM in ACCUM.
